fp16_div: RTL and testbench
===========================

Name: fp16_div

Overview:
- Sequential IEEE-754 half-precision divider (opA / opB). It is the inverse-operation companion to the team's combinational FP16 multiplier.
- Uses a radix-2 restoring mantissa divider, iterated over multiple cycles, with a valid/ready handshake on both input and output.
- Sits in the FP16 arithmetic cluster beside the add/multiply units and shares their operand format: sign[15], exp[14:10] with bias 15, frac[9:0].

Parameters:
- ITER_PER_CYCLE, default 1: quotient bits resolved per clock. Legal values are 1, 2, 7 and 14; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  operands valid.
- ready_o  out  1  divider can accept operands.
- opA_i  in  16  dividend (FP16).
- opB_i  in  16  divisor (FP16).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- DIV_o  out  16  quotient (FP16).
- flags_o  out  4  {invalid, divzero, overflow, underflow}.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - state = IDLE.
  - out_valid_o = 0, DIV_o = 16'h0000, flags_o = 4'h0.
  - All internal registers cleared.
  - Reset asserted mid-operation aborts the operation; no result is ever emitted for it.
- Handshake:
  - ready_o = (state == IDLE), decoded combinationally from state.
  - An operation is accepted on a rising edge where valid_i && ready_o.
  - Operands are captured at acceptance; later changes on the inputs are ignored.
- States:
  - IDLE -> DIV on accept.
  - DIV: runs 14/ITER_PER_CYCLE cycles, then -> NORM.
  - NORM: one cycle of normalise, round and pack, then -> DONE.
  - DONE: out_valid_o = 1; DIV_o and flags_o held stable. -> IDLE on the edge where out_ready_i = 1.
- Latency: out_valid_o rises exactly 14/ITER_PER_CYCLE + 2 edges after the accept edge. Special-case operands follow the same fixed latency; only their result mux differs.
- Throughput: one operation in flight. A new accept is possible on the edge after the result handshake.
- Operand classes:
  - exp = 0 means zero; denormals are flushed to zero.
  - exp = 31, frac = 0 means Inf.
  - exp = 31, frac != 0 means NaN.
  - Otherwise normal.
- Sign = signA ^ signB for every non-NaN result.
- Special cases, in priority order:
  1. Either operand NaN -> 16'h7E00, invalid = 1.
  2. 0/0 or Inf/Inf -> 16'h7E00, invalid = 1.
  3. Inf/x -> signed Inf (exp = 31, frac = 0).
  4. finite nonzero / 0 -> signed Inf, divzero = 1.
  5. x/Inf or 0/x -> signed zero, no flag.
- Datapath for normal operands:
  - mA = {1, fracA}, mB = {1, fracB} (11 bits each).
  - Q = floor(mA * 2^13 / mB), 14 bits, plus remainder R. Restoring divide, MSB first.
  - Exponent e = expA - expB + 15, held in a signed 7-bit register.
- Normalise:
  - If Q[13] = 1: mant = Q[13:3], round = Q[2], sticky = |Q[1:0] | (R != 0).
  - Else: mant = Q[12:2], round = Q[1], sticky = Q[0] | (R != 0), and e = e - 1.
- Rounding:
  - Rounding mode is set by the optional feature below.
  - If the mantissa carries out to 2048, shift it right by one and set e = e + 1.
- Range:
  - e >= 31 after rounding -> signed Inf, overflow = 1.
  - e <= 0 -> signed zero, underflow = 1.
  - Otherwise pack {sign, e[4:0], mant[9:0]}.
- Boundary conditions:
  - valid_i while busy: ignored, not queued.
  - out_ready_i while not in DONE: ignored.
  - valid_i and out_ready_i asserted together in DONE: only the output handshake occurs; the new operation can be accepted on the next cycle.

Optional Feature:
- Macro FP16_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment the mantissa when round && (sticky || mant[0]).
- Undefined: truncation. round and sticky are discarded, and the rounding incrementer is not synthesised.

Decomposition:
- Shared package fp16_pkg:
  - Constants: EXP_BIAS = 15, EXP_MAX = 31, QNAN = 16'h7E00, POS_INF = 16'h7C00.
  - Flag bit indices FLG_INVALID/DIVZERO/OVERFLOW/UNDERFLOW = 3/2/1/0.
  - Operand-class enum: ZERO, NORMAL, INF, NAN.
  - Divider state enum: IDLE, DIV, NORM, DONE.
- Sub-module fp16_classify: combinational, 16-bit operand in, class enum out. Instantiated twice here and reusable by the add/multiply units.

Test Plan:
1. 16'h4000 / 16'h3C00 (2.0 / 1.0), ITER_PER_CYCLE = 1 -> DIV_o = 16'h4000, flags 0. out_valid_o high exactly 16 edges after accept.
2. 16'h4500 / 16'h4200 (5 / 3) -> 16'h3EAB with FP16_DIV_ROUND_NEAREST_EN defined, 16'h3EAA without it. 16'h3C00 / 16'h4200 -> 16'h3555 in both builds.
3. Specials:
   - 16'h3C00 / 16'h0000 -> 16'h7C00, divzero.
   - 16'hBC00 / 16'h0000 -> 16'hFC00, divzero.
   - 16'h0000 / 16'h0000 -> 16'h7E00, invalid.
   - 16'h7C00 / 16'h7C00 -> 16'h7E00, invalid.
   - 16'h4000 / 16'h7C00 -> 16'h0000.
4. Range:
   - 16'h7BFF / 16'h3800 -> 16'h7C00, overflow.
   - 16'h0400 / 16'h4000 -> 16'h0000, underflow.
   - Denormal 16'h0001 / 16'h3C00 -> 16'h0000, no flag.
5. Backpressure: hold out_ready_i = 0 for 5 cycles in DONE and pulse valid_i with new operands.
   - DIV_o and flags_o stay stable; ready_o = 0; the second request is dropped.
   - After out_ready_i = 1, ready_o = 1 on the next cycle and the next request is accepted.
6. Reset mid-operation: drop rstn_i for 1 cycle, 5 cycles into DIV.
   - out_valid_o = 0 and DIV_o = 0 immediately; state returns to IDLE with ready_o = 1.
   - No result is emitted; a following 16'h4000 / 16'h3C00 completes normally.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the arithmetic cluster: operand layout,
// constants, flag bit positions, operand classes and divider FSM states.
package fp16_pkg;

   localparam int unsigned FP_W     = 16;
   localparam int unsigned EXP_W    = 5;
   localparam int unsigned FRAC_W   = 10;
   localparam int unsigned MANT_W   = FRAC_W + 1;
   localparam int unsigned FLG_W    = 4;
   localparam int unsigned EXP_BIAS = 15;

   localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
   localparam logic [FP_W-1:0]  QNAN    = 16'h7E00;
   localparam logic [FP_W-1:0]  POS_INF = 16'h7C00;

   localparam int unsigned FLG_INVALID   = 3;
   localparam int unsigned FLG_DIVZERO   = 2;
   localparam int unsigned FLG_OVERFLOW  = 1;
   localparam int unsigned FLG_UNDERFLOW = 0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

   typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_e;

endpackage

// File: rtl/fp16_div_if.sv
// Operand/result handshake bundle for fp16_div.
//   master: producer/consumer side (drives operands and out_ready_i)
//   slave : divider side (drives ready_o, out_valid_o, DIV_o, flags_o)
interface fp16_div_if;
   import fp16_pkg::*;

   logic             valid_i;
   logic             ready_o;
   logic [FP_W-1:0]  opA_i;
   logic [FP_W-1:0]  opB_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [FP_W-1:0]  DIV_o;
   logic [FLG_W-1:0] flags_o;

   modport master (
      output valid_i, opA_i, opB_i, out_ready_i,
      input  ready_o, out_valid_o, DIV_o, flags_o
   );

   modport slave (
      input  valid_i, opA_i, opB_i, out_ready_i,
      output ready_o, out_valid_o, DIV_o, flags_o
   );

endinterface

// File: rtl/fp16_classify.sv
// Combinational FP16 operand classifier (denormals are treated as zero).
//   op_i  : FP16 operand
//   cls_o : ZERO / NORMAL / INF / NAN
module fp16_classify
   import fp16_pkg::*;
(
   input  fp16_t     op_i,
   output fp_class_e cls_o
);

   // Sign does not affect the class.
   logic unused_sign;
   assign unused_sign = op_i.sign;

   always_comb begin : classify
      cls_o = NORMAL;
      if (op_i.exp == '0) begin
         cls_o = ZERO;
      end else if (op_i.exp == EXP_MAX) begin
         cls_o = (op_i.frac == '0) ? INF : NAN;
      end
   end

endmodule

// File: rtl/fp16_div.sv
// Sequential FP16 divider (opA / opB), radix-2 restoring mantissa divide.
//   clk_i, rstn_i : clock, async active-low reset
//   bus (slave)   : valid_i/ready_o operand handshake, opA_i, opB_i,
//                   out_valid_o/out_ready_i result handshake, DIV_o, flags_o
//                   flags_o = {invalid, divzero, overflow, underflow}
//   ITER_PER_CYCLE: quotient bits per clock (1, 2, 7 or 14)
// Build macro FP16_DIV_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the quotient is truncated.
module fp16_div
   import fp16_pkg::*;
#(
   parameter int unsigned ITER_PER_CYCLE = 1
) (
   input  logic      clk_i,
   input  logic      rstn_i,
   fp16_div_if.slave bus
);

   localparam int unsigned Q_W    = 14;
   localparam int unsigned N_ITER = Q_W / ITER_PER_CYCLE;
   localparam int unsigned REM_W  = MANT_W + 1;
   localparam int unsigned MR_W   = MANT_W + 1;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned E_W    = 7;
   localparam int unsigned EN_W   = 8;

   if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2 &&
       ITER_PER_CYCLE != 7 && ITER_PER_CYCLE != 14) begin : g_bad_iter
      $error("fp16_div: ITER_PER_CYCLE must be 1, 2, 7 or 14");
   end

   div_state_e              state_q, state_d;
   fp16_t                   op_a_q, op_b_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [REM_W-1:0]        rem_q, rem_n;
   logic [MANT_W-1:0]       mb_q;
   logic [Q_W-1:0]          q_q, q_n;
   logic signed [E_W-1:0]   e_q;
   logic [FP_W-1:0]         res_q, res_c;
   logic [FLG_W-1:0]        flg_q, flg_c;
   logic                    out_valid_q;

   logic ready_c, accept, prep_en, iter_en, norm_en, out_clr;

   fp_class_e cls_a, cls_b;

   fp16_classify u_cls_a (.op_i(op_a_q), .cls_o(cls_a));
   fp16_classify u_cls_b (.op_i(op_b_q), .cls_o(cls_b));

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin : fsm_reg
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state
   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.valid_i) state_d = DIV;
         DIV:     if (cnt_q == CNT_W'(N_ITER)) state_d = NORM;
         NORM:    state_d = DONE;
         DONE:    if (bus.out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM decode; first DIV cycle unpacks the captured operands, the rest iterate
   always_comb begin : fsm_out
      ready_c = 1'b0;
      accept  = 1'b0;
      prep_en = 1'b0;
      iter_en = 1'b0;
      norm_en = 1'b0;
      out_clr = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            accept  = bus.valid_i;
         end
         DIV: begin
            prep_en = (cnt_q == '0);
            iter_en = (cnt_q != '0);
         end
         NORM:    norm_en = 1'b1;
         DONE:    out_clr = bus.out_ready_i;
         default: ;
      endcase
   end

   assign bus.ready_o = ready_c;

   // ITER_PER_CYCLE restoring steps; remainder is kept pre-shifted for the next step
   always_comb begin : div_step
      rem_n = rem_q;
      q_n   = q_q;
      for (int unsigned k = 0; k < ITER_PER_CYCLE; k++) begin
         if (rem_n >= {1'b0, mb_q}) begin
            rem_n = rem_n - {1'b0, mb_q};
            q_n   = {q_n[Q_W-2:0], 1'b1};
         end else begin
            q_n   = {q_n[Q_W-2:0], 1'b0};
         end
         rem_n = rem_n << 1;
      end
   end

   // Normalise, round, range-check and special-case select
   logic [MANT_W-1:0]      mant;
   logic [MR_W-1:0]        mant_r;
   logic                   rnd, sticky, rem_nz, sign_c;
   logic signed [EN_W-1:0] e_n;

   always_comb begin : norm_pack
      rem_nz = |rem_q;
      sign_c = op_a_q.sign ^ op_b_q.sign;
      res_c  = '0;
      flg_c  = '0;
      if (q_q[Q_W-1]) begin
         mant   = q_q[13:3];
         rnd    = q_q[2];
         sticky = (|q_q[1:0]) | rem_nz;
         e_n    = EN_W'(e_q);
      end else begin
         mant   = q_q[12:2];
         rnd    = q_q[1];
         sticky = q_q[0] | rem_nz;
         e_n    = EN_W'(e_q) - 8'sd1;
      end
`ifdef FP16_DIV_ROUND_NEAREST_EN
      mant_r = {1'b0, mant} + MR_W'(rnd & (sticky | mant[0]));
`else
      mant_r = {1'b0, mant};
`endif
      if (mant_r[MANT_W]) begin
         mant_r = mant_r >> 1;
         e_n    = e_n + 8'sd1;
      end

      if (cls_a == NAN || cls_b == NAN ||
          (cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
         res_c              = QNAN;
         flg_c[FLG_INVALID] = 1'b1;
      end else if (cls_a == INF) begin
         res_c = {sign_c, POS_INF[FP_W-2:0]};
      end else if (cls_b == ZERO) begin
         res_c              = {sign_c, POS_INF[FP_W-2:0]};
         flg_c[FLG_DIVZERO] = 1'b1;
      end else if (cls_b == INF || cls_a == ZERO) begin
         res_c = {sign_c, (FP_W-1)'(0)};
      end else if (e_n >= 8'sd31) begin
         res_c               = {sign_c, POS_INF[FP_W-2:0]};
         flg_c[FLG_OVERFLOW] = 1'b1;
      end else if (e_n <= 8'sd0) begin
         res_c                = {sign_c, (FP_W-1)'(0)};
         flg_c[FLG_UNDERFLOW] = 1'b1;
      end else begin
         res_c = {sign_c, e_n[EXP_W-1:0], mant_r[FRAC_W-1:0]};
      end
   end

   // Hidden bit is implicit; round/sticky only feed the nearest-even build
   logic unused_bits;
   assign unused_bits = ^{mant_r[MANT_W-1], rnd, sticky};

   // Datapath and output registers
   always_ff @(posedge clk_i or negedge rstn_i) begin : dp_regs
      if (!rstn_i) begin
         op_a_q      <= '0;
         op_b_q      <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         mb_q        <= '0;
         q_q         <= '0;
         e_q         <= '0;
         res_q       <= '0;
         flg_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            op_a_q <= bus.opA_i;
            op_b_q <= bus.opB_i;
         end
         if (accept)              cnt_q <= '0;
         else if (state_q == DIV) cnt_q <= cnt_q + CNT_W'(1);
         if (prep_en) begin
            rem_q <= REM_W'({1'b1, op_a_q.frac});
            mb_q  <= {1'b1, op_b_q.frac};
            q_q   <= '0;
            e_q   <= E_W'({2'b00, op_a_q.exp}) - E_W'({2'b00, op_b_q.exp}) + E_W'(EXP_BIAS);
         end
         if (iter_en) begin
            rem_q <= rem_n;
            q_q   <= q_n;
         end
         if (norm_en) begin
            res_q       <= res_c;
            flg_q       <= flg_c;
            out_valid_q <= 1'b1;
         end else if (out_clr) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.DIV_o       = res_q;
   assign bus.flags_o     = flg_q;

endmodule

// File: tb/tb_fp16_div.sv
// Directed bench for fp16_div: vector table plus backpressure and
// mid-operation reset sequences.
module tb_fp16_div;

   localparam int unsigned ITER = 1;
   localparam int LAT = 14 / ITER + 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;

   fp16_div_if bus ();

   fp16_div #(.ITER_PER_CYCLE(ITER)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  flg;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   int n_checks = 0;
   int n_fail   = 0;

`ifdef FP16_DIV_ROUND_NEAREST_EN
   localparam logic [15:0] R_5_3 = 16'h3EAB;
   localparam logic [15:0] R_3_5 = 16'h38CD;
`else
   localparam logic [15:0] R_5_3 = 16'h3EAA;
   localparam logic [15:0] R_3_5 = 16'h38CC;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input string n, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input logic [3:0] f);
      vecs[i].name = n;
      vecs[i].a    = a;
      vecs[i].b    = b;
      vecs[i].res  = r;
      vecs[i].flg  = f;
   endtask

   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.opA_i   = a;
      bus.opB_i   = b;
      bus.valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.opA_i   = ~a;
      bus.opB_i   = ~b;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (bus.out_valid_o !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
      start_op(a, b);
      wait_valid(lat);
      r = bus.DIV_o;
      f = bus.flags_o;
      consume();
   endtask

   initial begin
      logic [15:0] r;
      logic [3:0]  f;
      int          lat;
      int          seen;

      bus.valid_i     = 1'b0;
      bus.opA_i       = '0;
      bus.opB_i       = '0;
      bus.out_ready_i = 1'b0;

      // flags: {invalid, divzero, overflow, underflow}
      set_vec( 0, "two_by_one",  16'h4000, 16'h3C00, 16'h4000, 4'b0000);
      set_vec( 1, "five_thirds", 16'h4500, 16'h4200, R_5_3,    4'b0000);
      set_vec( 2, "one_third",   16'h3C00, 16'h4200, 16'h3555, 4'b0000);
      set_vec( 3, "three_fifth", 16'h4200, 16'h4500, R_3_5,    4'b0000);
      set_vec( 4, "one_by_zero", 16'h3C00, 16'h0000, 16'h7C00, 4'b0100);
      set_vec( 5, "neg_by_zero", 16'hBC00, 16'h0000, 16'hFC00, 4'b0100);
      set_vec( 6, "zero_zero",   16'h0000, 16'h0000, 16'h7E00, 4'b1000);
      set_vec( 7, "inf_inf",     16'h7C00, 16'h7C00, 16'h7E00, 4'b1000);
      set_vec( 8, "x_by_inf",    16'h4000, 16'h7C00, 16'h0000, 4'b0000);
      set_vec( 9, "overflow",    16'h7BFF, 16'h3800, 16'h7C00, 4'b0010);
      set_vec(10, "underflow",   16'h0400, 16'h4000, 16'h0000, 4'b0001);
      set_vec(11, "denorm",      16'h0001, 16'h3C00, 16'h0000, 4'b0000);
      set_vec(12, "nan_a",       16'h7E01, 16'h3C00, 16'h7E00, 4'b1000);
      set_vec(13, "inf_by_zero", 16'h7C00, 16'h0000, 16'h7C00, 4'b0000);
      set_vec(14, "neg_half",    16'hBC00, 16'h4000, 16'hB800, 4'b0000);
      set_vec(15, "negzero",     16'h8000, 16'h4000, 16'h8000, 4'b0000);
      set_vec(16, "neginf",      16'hFC00, 16'h4000, 16'hFC00, 4'b0000);
      set_vec(17, "neg_div",     16'h3C00, 16'hBC00, 16'hBC00, 4'b0000);
      set_vec(18, "nan_b",       16'h3C00, 16'hFE00, 16'h7E00, 4'b1000);
      set_vec(19, "neg_uflow",   16'h8400, 16'h4000, 16'h8000, 4'b0001);

      // Reset state
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst_div",       32'(bus.DIV_o),       32'h0);
      check("rst_flags",     32'(bus.flags_o),     32'h0);
      check("rst_ready",     32'(bus.ready_o),     32'd1);
      @(negedge clk);
      rstn = 1'b1;

      // Vector table
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].a, vecs[i].b, r, f, lat);
         check({vecs[i].name, "_res"},   32'(r),   32'(vecs[i].res));
         check({vecs[i].name, "_flags"}, 32'(f),   32'(vecs[i].flg));
         check({vecs[i].name, "_lat"},   32'(lat), 32'(LAT));
      end

      // Backpressure: result held, busy requests dropped
      start_op(16'h4500, 16'h4200);
      wait_valid(lat);
      check("bp_lat", 32'(lat), 32'(LAT));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.valid_i = (i == 2);
         bus.opA_i   = 16'h4000;
         bus.opB_i   = 16'h3C00;
         @(posedge clk);
         #1;
         check("bp_hold_res",   32'(bus.DIV_o),       32'(R_5_3));
         check("bp_hold_flags", 32'(bus.flags_o),     32'h0);
         check("bp_ready",      32'(bus.ready_o),     32'd0);
         check("bp_valid",      32'(bus.out_valid_o), 32'd1);
      end
      // Release together with a new request: only the output handshake happens
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      bus.valid_i     = 1'b1;
      bus.opA_i       = 16'h3C00;
      bus.opB_i       = 16'h4000;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
      check("bp_rel_valid", 32'(bus.out_valid_o), 32'd0);
      check("bp_rel_ready", 32'(bus.ready_o),     32'd1);
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      wait_valid(lat);
      check("bp_next_lat", 32'(lat),          32'(LAT));
      check("bp_next_res", 32'(bus.DIV_o),    32'h3800);
      check("bp_next_flg", 32'(bus.flags_o),  32'h0);
      consume();

      // Reset five cycles into DIV aborts the operation
      start_op(16'h3C00, 16'h4200);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
      check("mid_rst_div",   32'(bus.DIV_o),       32'h0);
      check("mid_rst_flags", 32'(bus.flags_o),     32'h0);
      check("mid_rst_ready", 32'(bus.ready_o),     32'd1);
      @(negedge clk);
      rstn = 1'b1;
      seen = 0;
      repeat (3 * LAT) begin
         @(posedge clk);
         #1;
         if (bus.out_valid_o === 1'b1) seen++;
      end
      check("mid_rst_no_emit", 32'(seen), 32'd0);
      run_op(16'h4000, 16'h3C00, r, f, lat);
      check("post_rst_res", 32'(r),   32'h4000);
      check("post_rst_flg", 32'(f),   32'h0);
      check("post_rst_lat", 32'(lat), 32'(LAT));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
